// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and address decode for the data-memory responder
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              err;
        logic [ADDR_W-3:0] idx;
    } word_map_t;

    // Upper address bits take part in the range check, so nothing aliases back into the array.
    function automatic word_map_t map_addr(input logic [ADDR_W-1:0] addr, input int depth);
        word_map_t m;
        m.idx = addr[ADDR_W-1:2];
        m.err = (addr[1:0] != 2'b00) || ({2'b00, m.idx} >= 32'(depth));
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response channel between MEM stage and data memory
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-wide RAM with byte-write mask and registered read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rd_en,
    input  logic [3:0]                     wr_mask,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read register only moves on rd_en so it can hold a response indefinitely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with programmable wait states
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [3:0]        cnt;
    logic              write_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic              err_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rd_sel_q;
    logic [DATA_W-1:0] ram_q;

    word_map_t         req_map;
    logic              unused_map_idx;
    logic              idle;
    logic              go_resp;
    logic              cur_write;
    logic              cur_err;
    logic [AW-1:0]     cur_idx;
    logic [DATA_W-1:0] cur_wdata;
    logic [3:0]        cur_be;
    logic [3:0]        wr_mask;
    logic              rd_en;

    assign req_map        = map_addr(bus.req_addr, DEPTH_WORDS);
    assign unused_map_idx = &{1'b0, req_map.idx};

    assign idle = (state == IDLE);

    // With zero wait states the commit happens on the accept edge, straight from the request.
    assign go_resp = (idle && bus.req_valid && reset && (LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1));

    assign cur_write = idle ? bus.req_write           : write_q;
    assign cur_err   = idle ? req_map.err             : err_q;
    assign cur_idx   = idle ? req_map.idx[AW-1:0]     : idx_q;
    assign cur_wdata = idle ? bus.req_wdata           : wdata_q;
    assign cur_be    = idle ? bus.req_be              : be_q;

    assign wr_mask = (go_resp && cur_write && !cur_err) ? cur_be : 4'b0000;
    assign rd_en   = go_resp && !cur_write && !cur_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .wr_mask (wr_mask),
        .addr    (cur_idx),
        .wdata   (cur_wdata),
        .rdata   (ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q <= bus.req_write;
                        idx_q   <= req_map.idx[AW-1:0];
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_be;
                        err_q   <= req_map.err;
                        if (LATENCY == 0) begin
                            state       <= RESP;
                            cnt         <= 4'd0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_map.err;
                            rd_sel_q    <= !bus.req_write && !req_map.err;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rd_sel_q    <= !write_q && !err_q;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_sel_q    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = idle;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rd_sel_q ? ram_q : '0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the data-memory interface used by the pipelined MIPS core's MEM stage. It services one outstanding load or store through a valid/ready request channel and a valid/ready response channel, and inserts a programmable number of wait states. It also checks word alignment and address range. It replaces the single-cycle data memory when the core is built with a stalling MEM stage.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored; must be a power of two ≥ 4.
- LATENCY, 2: wait-state cycles between request acceptance and response; legal range 0–15.
- clk  input  1: single clock; all state changes on its rising edge.
- reset  input  1: asynchronous, active-low reset (asserted when 0).
- req_valid  input  1: initiator presents a request.
- req_ready  output  1: responder can accept a request.
- req_write  input  1: 1 = store, 0 = load.
- req_addr  input  32: byte address.
- req_wdata  input  32: store data.
- req_be  input  4: byte enables for stores; bit i covers wdata[8i+7:8i]; ignored on loads.
- rsp_valid  output  1: response present.
- rsp_ready  input  1: initiator consumes the response.
- rsp_rdata  output  32: load data; 0 for stores and for errors.
- rsp_err  output  1: request was misaligned (addr[1:0]≠0) or out of range (word index ≥ DEPTH_WORDS).

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, address, wdata, be and err.
  - Go to WAIT with the counter at LATENCY, or go directly to RESP if LATENCY = 0.
- WAIT:
  - req_ready = 0 and the counter decrements.
  - When the counter reaches 1, go to RESP on the next edge.
- Entering RESP:
  - Error: no array access, rdata = 0, err = 1.
  - Load: rdata = array[addr[log2(DEPTH_WORDS)+1:2]].
  - Store: write only the enabled bytes; rdata = 0.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_err stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- Only one request is in flight; there is no pipelining. req_ready is deasserted from acceptance until the response handshake completes.
- A store with req_be = 0 completes normally and changes no data.
- Address bits above the word index are checked for range and never wrap.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
  - Array contents are not reset.
- Latency from accept edge to first cycle of rsp_valid = LATENCY+1 cycles.
  - LATENCY = 0 gives rsp_valid in the cycle right after acceptance.
- Back-to-back throughput is one transaction per LATENCY+2 cycles when rsp_ready is held at 1. After the response handshake edge, req_ready is 1 in the following cycle.
- The store commits on the edge entering RESP. A load issued after a store's response therefore sees the new data.
- If reset asserts mid-transaction, the FSM returns to IDLE immediately.
  - A store not yet in RESP is dropped.
  - A store already committed stays in the array.
- Response outputs are registered. No output depends combinationally on req_* or rsp_ready, except that req_ready is a decode of state.
- req_* inputs are don't-care outside the accept cycle.

## Structure
- Package dmem_pkg holds:
  - the state enumeration (IDLE/WAIT/RESP);
  - data width 32 and address width 32;
  - a function mapping a byte address to a word index plus range/alignment error.
- One natural sub-module, dmem_array:
  - synchronous-write, synchronous-read RAM of DEPTH_WORDS × 32 with a 4-bit byte-write mask;
  - instantiated once and driven by the FSM's commit strobe.
- The wait counter is 4 bits wide.
- The FSM and latches stay in dmem_responder.

## Test plan
- Reset low for 2 cycles, then release → req_ready = 1 and rsp_valid = 0 during and after reset, with no spurious response.
- LATENCY = 2:
  - Store addr 0x10, data 0xDEADBEEF, be = 0xF → rsp_valid 3 cycles after acceptance, rsp_err = 0, rsp_rdata = 0.
  - Then load 0x10 → rsp_rdata = 0xDEADBEEF.
- Store addr 0x10, data 0x00000055, be = 4'b0001 over 0xDEADBEEF → a following load returns 0xDEADBE55.
- Load addr 0x13 (misaligned), and separately load addr 0x400 with DEPTH_WORDS = 256 → rsp_err = 1, rsp_rdata = 0, array unchanged.
- Response backpressure:
  - hold rsp_ready = 0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err are stable and req_ready = 0 throughout;
  - a new req_valid offered during this time is not accepted until one cycle after the handshake.
- Reset asserted during WAIT of a store to 0x20 (old value 0x11111111) → FSM returns to IDLE and a later load of 0x20 returns 0x11111111.
- Repeat the store/load scenario with LATENCY = 0 → response in the cycle right after acceptance.
